spi_slave_regfile: RTL and testbench

- SPI slave register bank sitting directly downstream of the team's 4-wire SPI master, on the far side of sclk/cs/mosi/miso.
- Decodes the master's 12-bit frame {rw, addr[2:0], data[7:0]}, MSB first. rw=1 writes one of 8 byte registers; rw=0 returns the addressed byte on miso in the 8-clock read-data phase that follows.
- Runs on a 100 MHz system clock and oversamples a 10 MHz sclk. Also exposes a local parallel write port and all register contents to on-chip logic.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_slave_regfile_if.sv | 12 +
 rtl/spi_sync_edge.sv | 46 ++++
 rtl/spi_slave_regfile.sv | 176 +++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame layout and slave FSM encoding, used by both the SPI master
// and the slave register bank.
package spi_pkg;

  localparam logic        RW_WRITE   = 1'b1;
  localparam int unsigned RW_BIT     = 11;
  localparam int unsigned ADDR_MSB   = 10;
  localparam int unsigned ADDR_LSB   = 8;
  localparam int unsigned DATA_MSB   = 7;
  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned RD_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_DATA = 2'd2,
    HOLD    = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// 4-wire SPI pin bundle between the master and the slave register bank.
interface spi_slave_regfile_if;

  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs, output mosi, input miso);
  modport slave  (input sclk, input cs, input mosi, output miso);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin, with optional
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0,
  parameter bit          EDGE_DET  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_d, sync_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

  if (EDGE_DET) begin : g_edge
    logic prev_d, prev_q;

    assign prev_d = q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= RESET_VAL;
      else        prev_q <= prev_d;
    end

    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave register bank: decodes {rw, addr, data} frames from an oversampled
// SPI bus, plus a local parallel write port; all registers exported flat.
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int unsigned           RW_FLAG     = 1,
  parameter int unsigned           ADDR_WIDTH  = ADDR_MSB - ADDR_LSB + 1,
  parameter int unsigned           DATA_WIDTH  = RD_BITS,
  parameter int unsigned           CMD_WIDTH   = RW_FLAG + ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  spi_slave_regfile_if.slave                   spi,
  input  logic                                 local_wr_en,
  input  logic [ADDR_WIDTH-1:0]                local_addr,
  input  logic [DATA_WIDTH-1:0]                local_wdata,
  output logic                                 spi_wr_pulse,
  output logic [ADDR_WIDTH-1:0]                spi_wr_addr,
  output logic [DATA_WIDTH-1:0]                spi_wr_data,
  output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] regs_flat
);

  localparam int unsigned DEPTH   = 2**ADDR_WIDTH;
  localparam int unsigned CNT_MAX = CMD_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_CMD_DONE = CNT_W'(CMD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_RD_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DET(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi.sclk),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_DET(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi.cs),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DET(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi.mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e                state_d, state_q;
  logic [CNT_W-1:0]          bit_cnt_d, bit_cnt_q;
  logic [CMD_WIDTH-2:0]      cmd_d, cmd_q;
  logic [DATA_WIDTH-1:0]     rd_shift_d, rd_shift_q;
  logic                      miso_d, miso_q;
  logic                      wr_pulse_d, wr_pulse_q;
  logic [ADDR_WIDTH-1:0]     wr_addr_d, wr_addr_q;
  logic [DATA_WIDTH-1:0]     wr_data_d, wr_data_q;
  logic [DATA_WIDTH-1:0]     regs_d [DEPTH];
  logic [DATA_WIDTH-1:0]     regs_q [DEPTH];

  logic [CMD_WIDTH-1:0]      frame;
  logic [ADDR_WIDTH-1:0]     frame_addr;
  logic [DATA_WIDTH-1:0]     frame_data;
  logic                      frame_rw;

  // The current mosi bit completes the frame in the same cycle as the 12th rise.
  assign frame      = {cmd_q, mosi_s};
  assign frame_rw   = frame[CMD_WIDTH-1];
  assign frame_addr = frame[DATA_WIDTH +: ADDR_WIDTH];
  assign frame_data = frame[DATA_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    rd_shift_d = rd_shift_q;
    miso_d     = miso_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;

    if (local_wr_en) regs_d[local_addr] = local_wdata;

    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      if (sclk_rise && state_q != IDLE && bit_cnt_q != CNT_SAT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          miso_d    = 1'b0;
          if (!cs_s) state_d = CMD;
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_d = frame[CMD_WIDTH-2:0];
            if (bit_cnt_q == CNT_CMD_LAST) begin
              if (frame_rw == RW_WRITE) begin
                // SPI commit is applied after the local write so it wins on a collision.
                regs_d[frame_addr] = frame_data;
                wr_pulse_d         = 1'b1;
                wr_addr_d          = frame_addr;
                wr_data_d          = frame_data;
                state_d            = HOLD;
              end else begin
                rd_shift_d = regs_q[frame_addr];
                miso_d     = regs_q[frame_addr][DATA_WIDTH-1];
                state_d    = RD_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (sclk_rise) begin
            if (bit_cnt_q == CNT_RD_LAST) begin
              miso_d  = 1'b0;
              state_d = HOLD;
            end
          end else if (sclk_fall && bit_cnt_q > CNT_CMD_DONE && bit_cnt_q < CNT_SAT) begin
            rd_shift_d = rd_shift_q << 1;
            miso_d     = rd_shift_q[DATA_WIDTH-2];
          end
        end
        HOLD: begin
          miso_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      cmd_q      <= '0;
      rd_shift_q <= '0;
      miso_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      rd_shift_q <= rd_shift_d;
      miso_q     <= miso_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign spi.miso     = miso_q;
  assign spi_wr_pulse = wr_pulse_q;
  assign spi_wr_addr  = wr_addr_q;
  assign spi_wr_data  = wr_data_q;

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: drives SPI frames at 10 MHz sclk
// against a 100 MHz clk and checks registers, write pulses and read data.
module tb_spi_slave_regfile;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        local_wr_en;
  logic [2:0]  local_addr;
  logic [7:0]  local_wdata;
  logic        spi_wr_pulse;
  logic [2:0]  spi_wr_addr;
  logic [7:0]  spi_wr_data;
  logic [63:0] regs_flat;

  int n_vec     = 0;
  int n_miss    = 0;
  int pulse_cnt = 0;
  int p0;

  logic [7:0] exp_regs [8];
  logic [7:0] rd;
  logic       extra;

  spi_slave_regfile_if spi_bus ();

  always #5 clk = ~clk;

  spi_slave_regfile #(
    .RW_FLAG(1), .ADDR_WIDTH(3), .DATA_WIDTH(8), .SYNC_STAGES(2), .RESET_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi_bus),
    .local_wr_en(local_wr_en), .local_addr(local_addr), .local_wdata(local_wdata),
    .spi_wr_pulse(spi_wr_pulse), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .regs_flat(regs_flat)
  );

  always @(negedge clk) if (rst_n && spi_wr_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = exp_regs[i];
    return f;
  endfunction

  function automatic logic [FRAME_BITS-1:0] mk_frame(input logic rw, input logic [2:0] a,
                                                     input logic [7:0] d);
    logic [FRAME_BITS-1:0] f;
    f                    = '0;
    f[RW_BIT]            = rw;
    f[ADDR_MSB:ADDR_LSB] = a;
    f[DATA_MSB:0]        = d;
    return f;
  endfunction

  // Mode-0 master: mosi set while sclk low, miso sampled on each data-phase rise.
  task automatic spi_xfer(input logic [FRAME_BITS-1:0] frame, input int n_cmd,
                          input int n_data, output logic [7:0] rdata, output logic ext);
    rdata = '0;
    ext   = 1'b0;
    spi_bus.cs = 1'b0;
    #100;
    for (int i = 0; i < n_cmd; i++) begin
      spi_bus.mosi = frame[FRAME_BITS-1-i];
      #50 spi_bus.sclk = 1'b1;
      #50 spi_bus.sclk = 1'b0;
    end
    spi_bus.mosi = 1'b0;
    if (n_data > 0) begin
      #1000;
      for (int i = 0; i < n_data; i++) begin
        #50 spi_bus.sclk = 1'b1;
        if (i < RD_BITS) rdata = {rdata[6:0], spi_bus.miso};
        else             ext   = ext | spi_bus.miso;
        #50 spi_bus.sclk = 1'b0;
      end
    end
    #100 spi_bus.cs = 1'b1;
    #200;
  endtask

  task automatic local_write(input logic [2:0] a, input logic [7:0] d);
    local_addr  = a;
    local_wdata = d;
    local_wr_en = 1'b1;
    #10 local_wr_en = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    spi_bus.cs   = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.mosi = 1'b0;
    local_wr_en  = 1'b0;
    local_addr   = '0;
    local_wdata  = '0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

    #20;
    check("rst_regs",  regs_flat, 64'h0);
    check("rst_miso",  64'(spi_bus.miso), 64'h0);
    check("rst_pulse", 64'(spi_wr_pulse), 64'h0);
    check("rst_waddr", 64'(spi_wr_addr), 64'h0);
    check("rst_wdata", 64'(spi_wr_data), 64'h0);
    #20 rst_n = 1'b1;
    #40;

    // Write 0xA5 to reg 3; 12th rise at +1250, commit lands 3 clk later.
    p0 = pulse_cnt;
    fork
      spi_xfer(mk_frame(RW_WRITE, 3'd3, 8'hA5), FRAME_BITS, 0, rd, extra);
      begin
        #1270;
        check("wr_pre_commit", 64'(regs_flat[3*8 +: 8]), 64'h00);
        #10;
        check("wr_commit_reg", 64'(regs_flat[3*8 +: 8]), 64'hA5);
        check("wr_pulse_hi", 64'(spi_wr_pulse), 64'h1);
        #10;
        check("wr_pulse_lo", 64'(spi_wr_pulse), 64'h0);
      end
    join
    exp_regs[3] = 8'hA5;
    check("wr_regs",  regs_flat, exp_flat());
    check("wr_npulse", 64'(pulse_cnt - p0), 64'd1);
    check("wr_addr",  64'(spi_wr_addr), 64'd3);
    check("wr_data",  64'(spi_wr_data), 64'hA5);

    p0 = pulse_cnt;
    spi_xfer(mk_frame(1'b0, 3'd3, 8'h00), FRAME_BITS, RD_BITS, rd, extra);
    check("rd_a5", 64'(rd), 64'hA5);
    check("rd_no_pulse", 64'(pulse_cnt - p0), 64'd0);

    // Aborted write after 6 clocks must leave everything untouched.
    p0 = pulse_cnt;
    spi_xfer(mk_frame(RW_WRITE, 3'd5, 8'hFF), 6, 0, rd, extra);
    check("part_regs",  regs_flat, exp_flat());
    check("part_pulse", 64'(pulse_cnt - p0), 64'd0);
    spi_xfer(mk_frame(RW_WRITE, 3'd5, 8'h3C), FRAME_BITS, 0, rd, extra);
    exp_regs[5] = 8'h3C;
    check("wr5_regs", regs_flat, exp_flat());
    check("wr5_addr", 64'(spi_wr_addr), 64'd5);
    check("wr5_data", 64'(spi_wr_data), 64'h3C);

    // Local write in the exact commit clock, same address: SPI data must win.
    fork
      spi_xfer(mk_frame(RW_WRITE, 3'd2, 8'hC3), FRAME_BITS, 0, rd, extra);
      begin #1270 local_write(3'd2, 8'h5A); end
    join
    exp_regs[2] = 8'hC3;
    check("coll_same", regs_flat, exp_flat());

    fork
      spi_xfer(mk_frame(RW_WRITE, 3'd2, 8'h66), FRAME_BITS, 0, rd, extra);
      begin #1270 local_write(3'd4, 8'h5A); end
    join
    exp_regs[2] = 8'h66;
    exp_regs[4] = 8'h5A;
    check("coll_diff", regs_flat, exp_flat());

    // Read snapshot vs. local overwrite during data phase; 24 sclks total.
    local_write(3'd6, 8'h81);
    #20;
    exp_regs[6] = 8'h81;
    check("preload6", regs_flat, exp_flat());
    fork
      spi_xfer(mk_frame(1'b0, 3'd6, 8'h00), FRAME_BITS, 12, rd, extra);
      begin #2500 local_write(3'd6, 8'h00); end
    join
    exp_regs[6] = 8'h00;
    check("rd_snapshot", 64'(rd), 64'h81);
    check("rd_extra_zero", 64'(extra), 64'h0);
    check("local_ovr6", regs_flat, exp_flat());

    // Reset in the middle of reading reg 5 (0x3C): miso is 1 at +2560.
    fork
      spi_xfer(mk_frame(1'b0, 3'd5, 8'h00), FRAME_BITS, RD_BITS, rd, extra);
      begin
        #2560;
        check("miso_pre_rst", 64'(spi_bus.miso), 64'h1);
        rst_n = 1'b0;
        #1;
        check("miso_rst", 64'(spi_bus.miso), 64'h0);
        check("regs_rst", regs_flat, 64'h0);
        check("waddr_rst", 64'(spi_wr_addr), 64'h0);
        #9;
      end
    join
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    #20 rst_n = 1'b1;
    #40;
    p0 = pulse_cnt;
    spi_xfer(mk_frame(RW_WRITE, 3'd1, 8'h42), FRAME_BITS, 0, rd, extra);
    exp_regs[1] = 8'h42;
    check("post_rst_regs",  regs_flat, exp_flat());
    check("post_rst_pulse", 64'(pulse_cnt - p0), 64'd1);
    check("post_rst_data",  64'(spi_wr_data), 64'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
